exec_unit: RTL and testbench
============================

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result/PC width (4..32).
REQ-002 SHALL have parameter ADDR_W, default 8, data-memory address width; depth 2^ADDR_W words of DATA_W.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have ports src1, src2, wdata  input  DATA_W  operands and store data.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  DATA_W  operation result.
REQ-012 SHALL have ports zero, carry, ovf, err  output  1 each  result flags, illegal-op flag.
REQ-013 SHALL have port pc  output  DATA_W  program counter.

Function
REQ-014 Opcodes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 LW, 7 SW, 8 BEQ, 9 MUL (low DATA_W bits); 10-15 illegal.
REQ-015 Request SHALL be accepted on a cycle with in_valid and in_ready high; operands and op are registered at acceptance.
REQ-016 FSM states SHALL be IDLE, EXEC, MEM, MUL, DONE; in_ready high only in IDLE.
REQ-017 IDLE->EXEC on acceptance of ops 0-5, 7, 8 and illegal ops; IDLE->MEM for LW; IDLE->MUL for MUL.
REQ-018 EXEC->DONE after one cycle; MEM->DONE after one cycle (synchronous memory read); MUL->DONE after DATA_W shift-add iterations.
REQ-019 Latency acceptance-to-out_valid SHALL be 2 cycles for EXEC ops, 3 for LW, DATA_W+2 for MUL.
REQ-020 In DONE, out_valid SHALL be high and result/flags stable until out_ready is sampled high; then DONE->IDLE.
REQ-021 ADD/SUB SHALL wrap modulo 2^DATA_W; carry = carry-out (ADD) or borrow (SUB); ovf = signed overflow; carry=ovf=0 for other ops.
REQ-022 zero SHALL equal (result == 0) for every completed op.
REQ-023 Memory address SHALL be low ADDR_W bits of (src1+src2), carry discarded (wrap-around).
REQ-024 SW SHALL write wdata to memory in the EXEC cycle; result = computed address zero-extended.
REQ-025 LW SHALL return memory word at computed address; a SW completed earlier SHALL be visible to a subsequent LW.
REQ-026 BEQ SHALL produce result = src1-src2; zero flag reflects equality.
REQ-027 pc SHALL update once per op at DONE->IDLE: pc+src2 (wrap) if BEQ and src1==src2, else pc+1 (wrap).
REQ-028 Illegal op SHALL complete via EXEC with result 0, err=1, memory and pc unchanged except pc+1; err=0 for legal ops.
REQ-029 in_valid while busy SHALL be ignored (no acceptance, no state change).
REQ-030 MUL SHALL accept src2=0 and produce result 0, zero=1, after the full DATA_W+2 latency.

Reset
REQ-031 Reset SHALL force state IDLE, pc=0, result=0, out_valid=0, zero=1, carry=ovf=err=0, in_ready=1, asynchronously.
REQ-032 Reset mid-operation SHALL abort the op: no memory write after reset assertion, no out_valid, pc=0.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-034 DATA_W=8: ADD 8'hF0+8'h20 -> result 8'h10, carry=1, ovf=0, out_valid 2 cycles after acceptance.
REQ-035 SUB 8'h80-8'h01 -> 8'h7F, ovf=1, carry=0; SLT 8'hFF,8'h01 -> 1.
REQ-036 SW src1=8'hFE,src2=8'h03,wdata=8'hA5 then LW 8'h00,8'h01 -> result 8'hA5 (address wrap to 8'h01), LW latency 3.
REQ-037 BEQ 8'h33,8'h33 with pc=8'hFE and src2=8'h33 as offset -> pc 8'h31; BEQ unequal -> pc+1; out_ready held low 5 cycles -> result stable, pc updates only on handshake.
REQ-038 MUL 8'h0D*8'h0B -> 8'h8F after 10 cycles; reset asserted during MUL cycle 4 -> out_valid 0, pc 0, in_ready 1; op 4'hC -> err=1, result 0.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execution unit with ALU ops, a word-addressed data
// memory (LW/SW), a branch-on-equal program counter and a shift-add
// multiplier. A single request is in flight at a time; the result is held
// in DONE until the consumer takes it with out_ready.
module exec_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              ovf,
    output logic              err,
    output logic [DATA_W-1:0] pc
);

    // ------------------------------------------------------------------
    // Encodings and derived sizes
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_BEQ = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam int MSB   = DATA_W - 1;
    localparam int DEPTH = 1 << ADDR_W;
    // Counter must reach DATA_W (multiplier iterations) and 1 (memory phase).
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_MUL,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;

    logic [3:0]          r_op;
    logic [DATA_W-1:0]   r_src1;
    logic [DATA_W-1:0]   r_src2;
    logic [DATA_W-1:0]   r_wdata;

    // Shared step counter: multiplier iteration count, or LW read phase.
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   r_mul_acc;
    logic [DATA_W-1:0]   r_mul_mcand;
    logic [DATA_W-1:0]   r_mul_mplier;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rdata;

    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_carry;
    logic                r_ovf;
    logic                r_err;
    logic [DATA_W-1:0]   r_pc;

    // ------------------------------------------------------------------
    // Control strobes from the FSM
    // ------------------------------------------------------------------
    logic                w_accept;     // request taken this cycle
    logic                w_latch;      // final cycle of an op: capture result/flags
    logic                w_mul_step;   // one shift-add iteration
    logic                w_mem_rd;     // synchronous memory read issue
    logic                w_mem_we;     // SW write strobe
    logic                w_handshake;  // result consumed, pc advances

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic [DATA_W:0]     w_add_full;
    logic [DATA_W:0]     w_sub_full;
    logic                w_add_ovf;
    logic                w_sub_ovf;
    logic [DATA_W-1:0]   w_sum;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_addr_ext;
    logic                w_slt;
    logic                w_beq_taken;

    logic [DATA_W-1:0]   w_res_next;
    logic                w_carry_next;
    logic                w_ovf_next;
    logic                w_err_next;

    // Carry-out and borrow fall out of the extra top bit of the extended sum/difference.
    assign w_add_full = {1'b0, r_src1} + {1'b0, r_src2};
    assign w_sub_full = {1'b0, r_src1} - {1'b0, r_src2};
    assign w_add_ovf  = (r_src1[MSB] == r_src2[MSB]) && (w_add_full[MSB] != r_src1[MSB]);
    assign w_sub_ovf  = (r_src1[MSB] != r_src2[MSB]) && (w_sub_full[MSB] != r_src1[MSB]);
    assign w_slt      = $signed(r_src1) < $signed(r_src2);

    // Memory address: DATA_W-bit sum (carry dropped), then its low ADDR_W bits.
    assign w_sum       = r_src1 + r_src2;
    assign w_addr      = ADDR_W'(w_sum);
    assign w_addr_ext  = DATA_W'(w_addr);

    assign w_beq_taken = (r_op == OP_BEQ) && (r_src1 == r_src2);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign pc        = r_pc;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; asserting reset drops any op in flight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; requests arriving while busy are ignored.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_latch      = 1'b0;
        w_mul_step   = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_we     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (op == OP_LW) begin
                        w_state_next = S_MEM;
                    end else if (op == OP_MUL) begin
                        w_state_next = S_MUL;
                    end else begin
                        w_state_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_latch      = 1'b1;
                w_mem_we     = (r_op == OP_SW);
                w_state_next = S_DONE;
            end
            S_MEM: begin
                // First cycle issues the read, second captures the returned word.
                if (r_cnt == '0) begin
                    w_mem_rd = 1'b1;
                end else begin
                    w_latch      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_MUL: begin
                // DATA_W iterations, then one cycle to capture the product.
                if (r_cnt < CNT_W'(DATA_W)) begin
                    w_mul_step = 1'b1;
                end else begin
                    w_latch      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Capture operands and opcode at acceptance so the bus may change freely afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op    <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= op;
            r_src1  <= src1;
            r_src2  <= src2;
            r_wdata <= wdata;
        end
    end

    // Step counter: cleared on acceptance, advanced per read phase or multiply iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_mem_rd || w_mul_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shift-add multiplier keeping only the low DATA_W bits of the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_acc    <= '0;
            r_mul_mcand  <= '0;
            r_mul_mplier <= '0;
        end else if (w_accept) begin
            r_mul_acc    <= '0;
            r_mul_mcand  <= src1;
            r_mul_mplier <= src2;
        end else if (w_mul_step) begin
            r_mul_acc    <= r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : '0);
            r_mul_mcand  <= r_mul_mcand << 1;
            r_mul_mplier <= r_mul_mplier >> 1;
        end
    end

    // Data memory: synchronous write for SW, synchronous read for LW.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; its contents persist across reset.
        // Writes are still blocked by reset because the strobe depends on r_state.
        if (w_mem_we) begin
            r_mem[w_addr] <= r_wdata;
        end
        if (w_mem_rd) begin
            r_rdata <= r_mem[w_addr];
        end
    end

    // Result and flag selection for the op finishing this cycle.
    always_comb begin
        w_res_next   = '0;
        w_carry_next = 1'b0;
        w_ovf_next   = 1'b0;
        w_err_next   = 1'b0;
        if (r_state == S_MEM) begin
            w_res_next = r_rdata;
        end else if (r_state == S_MUL) begin
            w_res_next = r_mul_acc;
        end else begin
            case (r_op)
                OP_ADD: begin
                    w_res_next   = w_add_full[DATA_W-1:0];
                    w_carry_next = w_add_full[DATA_W];
                    w_ovf_next   = w_add_ovf;
                end
                OP_SUB: begin
                    w_res_next   = w_sub_full[DATA_W-1:0];
                    w_carry_next = w_sub_full[DATA_W];
                    w_ovf_next   = w_sub_ovf;
                end
                OP_AND: w_res_next = r_src1 & r_src2;
                OP_OR:  w_res_next = r_src1 | r_src2;
                OP_XOR: w_res_next = r_src1 ^ r_src2;
                OP_SLT: w_res_next = {{(DATA_W-1){1'b0}}, w_slt};
                OP_SW:  w_res_next = w_addr_ext;
                OP_BEQ: w_res_next = w_sub_full[DATA_W-1:0];
                OP_LW, OP_MUL: w_res_next = '0;
                default: w_err_next = 1'b1;
            endcase
        end
    end

    // Result/flag registers; they only change when an op completes, so they
    // stay stable throughout DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_latch) begin
            r_result <= w_res_next;
            r_zero   <= (w_res_next == '0);
            r_carry  <= w_carry_next;
            r_ovf    <= w_ovf_next;
            r_err    <= w_err_next;
        end
    end

    // Program counter advances once per op, at the result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_handshake) begin
            if (w_beq_taken) begin
                r_pc <= r_pc + r_src2;
            end else begin
                r_pc <= r_pc + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and randomized checks of exec_unit against an
// arithmetic reference model (integer math, array memory, pc counter).
module tb_exec_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MOD    = 1 << DATA_W;
    localparam int HALF   = MOD / 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] wdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              ovf;
    logic              err;
    logic [DATA_W-1:0] pc;

    exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .wdata     (wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int mdl_mem [DEPTH];
    int mdl_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    // Expected outcome of one op from the arithmetic definitions.
    function automatic void ref_op(input int o, input int a, input int b,
                                   output int res, output int c, output int v,
                                   output int e, output int lat);
        int t;
        res = 0; c = 0; v = 0; e = 0; lat = 2;
        case (o)
            0: begin
                t = a + b; res = t % MOD; c = (t >= MOD) ? 1 : 0;
                t = to_signed(a) + to_signed(b); v = (t >= HALF || t < -HALF) ? 1 : 0;
            end
            1: begin
                res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0;
                t = to_signed(a) - to_signed(b); v = (t >= HALF || t < -HALF) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (to_signed(a) < to_signed(b)) ? 1 : 0;
            6: begin res = mdl_mem[((a + b) % MOD) % DEPTH]; lat = 3; end
            7: res = ((a + b) % MOD) % DEPTH;
            8: res = (a - b + MOD) % MOD;
            9: begin res = (a * b) % MOD; lat = DATA_W + 2; end
            default: e = 1;
        endcase
    endfunction

    // Issue one op, count edges to out_valid (acceptance edge = 1), hold the
    // result for 'hold' cycles with out_ready low, then hand it off.
    task automatic do_op(input int o, input int a, input int b, input int wd,
                         input int hold, output logic [DATA_W-1:0] res_obs);
        int    e_res, e_c, e_v, e_e, e_lat, lat, pc_before;
        string tag;
        tag = $sformatf("op%0d(%0h,%0h)", o, a, b);
        ref_op(o, a, b, e_res, e_c, e_v, e_e, e_lat);
        if (o == 7) mdl_mem[((a + b) % MOD) % DEPTH] = wd;
        pc_before = mdl_pc;

        check({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        op       = 4'(o);
        src1     = DATA_W'(a);
        src2     = DATA_W'(b);
        wdata    = DATA_W'(wd);
        @(posedge clk); #1;
        lat = 1;
        while (!out_valid && lat < 64) begin
            // Requests presented while busy must be ignored.
            in_valid = 1'($urandom);
            op       = 4'($urandom);
            src1     = DATA_W'($urandom);
            src2     = DATA_W'($urandom);
            wdata    = DATA_W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " result"}, result, e_res);
        check({tag, " zero"}, zero, (e_res == 0) ? 1 : 0);
        check({tag, " carry"}, carry, e_c);
        check({tag, " ovf"}, ovf, e_v);
        check({tag, " err"}, err, e_e);
        check({tag, " pc before handshake"}, pc, pc_before);
        res_obs = result;

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            op       = 4'($urandom);
            @(posedge clk); #1;
            check({tag, " held out_valid"}, out_valid, 1);
            check({tag, " held result"}, result, e_res);
            check({tag, " held pc"}, pc, pc_before);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (o == 8 && a == b) mdl_pc = (mdl_pc + b) % MOD;
        else                  mdl_pc = (mdl_pc + 1) % MOD;
        check({tag, " out_valid after handshake"}, out_valid, 0);
        check({tag, " pc after handshake"}, pc, mdl_pc);
        check({tag, " in_ready after handshake"}, in_ready, 1);
    endtask

    initial begin
        logic [DATA_W-1:0] r;
        int off, addr, old;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        src1      = '0;
        src2      = '0;
        wdata     = '0;
        mdl_pc    = 0;

        // Reset values while reset is held
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset zero", zero, 1);
        check("reset carry", carry, 0);
        check("reset ovf", ovf, 0);
        check("reset err", err, 0);
        check("reset pc", pc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Fill every memory word so later loads read known data
        for (int i = 0; i < DEPTH; i++) begin
            do_op(7, i, 0, int'($urandom_range(0, MOD - 1)), 0, r);
        end

        // Directed cases
        do_op(0, 'hF0, 'h20, 0, 0, r);
        check("ADD F0+20", r, 'h10);
        do_op(1, 'h80, 'h01, 0, 0, r);
        check("SUB 80-01", r, 'h7F);
        do_op(5, 'hFF, 'h01, 0, 0, r);
        check("SLT FF,01", r, 1);
        do_op(7, 'hFE, 'h03, 'hA5, 0, r);
        check("SW wrap address", r, 'h01);
        do_op(6, 'h00, 'h01, 0, 0, r);
        check("LW after SW", r, 'hA5);

        off = (254 - mdl_pc + MOD) % MOD;
        do_op(8, off, off, 0, 0, r);
        check("BEQ to FE pc", pc, 'hFE);
        do_op(8, 'h33, 'h33, 0, 5, r);
        check("BEQ taken wrap pc", pc, 'h31);
        do_op(8, 'h12, 'h34, 0, 2, r);
        check("BEQ not taken pc", pc, 'h32);

        do_op(9, 'h0D, 'h0B, 0, 0, r);
        check("MUL 0D*0B", r, 'h8F);
        do_op(9, 'h5A, 'h00, 0, 1, r);
        check("MUL by zero", r, 0);
        do_op(12, 'h44, 'h55, 0, 0, r);
        check("illegal result", r, 0);

        // Randomized ops, with equal operands often enough to exercise BEQ taken
        for (int i = 0; i < 200; i++) begin
            int o, a, b;
            o = int'($urandom_range(0, 15));
            a = int'($urandom_range(0, MOD - 1));
            b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, MOD - 1));
            do_op(o, a, b, int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 2)), r);
        end

        // Reset during the fourth MUL cycle aborts the op
        in_valid = 1'b1;
        op       = 4'd9;
        src1     = 8'h0D;
        src2     = 8'h0B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        mdl_pc = 0;
        check("abort MUL out_valid", out_valid, 0);
        check("abort MUL in_ready", in_ready, 1);
        check("abort MUL pc", pc, 0);
        check("abort MUL result", result, 0);
        check("abort MUL zero", zero, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post-abort out_valid", out_valid, 0);
        check("post-abort in_ready", in_ready, 1);

        // Reset during a SW's execute cycle must block the write
        addr     = int'($urandom_range(0, DEPTH - 1));
        old      = mdl_mem[addr];
        in_valid = 1'b1;
        op       = 4'd7;
        src1     = DATA_W'(addr);
        src2     = '0;
        wdata    = DATA_W'(~old);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort SW pc", pc, 0);
        @(posedge clk); #1;
        do_op(6, addr, 0, 0, 0, r);
        check("LW after aborted SW", r, old);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
